// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: state encoding and
// sizing helpers for the digit count and its counter.
package digit_serial_addsub_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dsa_state_e;

  // Number of DIGIT-wide slices that make up a WIDTH-bit operand.
  function automatic int dsa_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width able to index every digit; never narrower than one bit.
  function automatic int dsa_cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Start/busy/done operand and result bundle of the digit-serial adder/subtractor.
// OVF is present only when DSA_OVERFLOW_EN is defined.
interface digit_serial_addsub_if #(
  parameter int WIDTH = 16
);

  logic             START;
  logic             SUB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             Co;
`ifdef DSA_OVERFLOW_EN
  logic             OVF;
`endif

  modport master (
    output START,
    output SUB,
    output A,
    output B,
    output Ci,
    input  BUSY,
    input  DONE,
    input  S,
`ifdef DSA_OVERFLOW_EN
    input  OVF,
`endif
    input  Co
  );

  modport slave (
    input  START,
    input  SUB,
    input  A,
    input  B,
    input  Ci,
    output BUSY,
    output DONE,
    output S,
`ifdef DSA_OVERFLOW_EN
    output OVF,
`endif
    output Co
  );

endinterface

// File: rtl/digit_serial_addsub_cpa_digit.sv
// DIGIT-bit combinational ripple-carry adder slice. With DSA_OVERFLOW_EN it also
// exposes the carry entering its top bit for signed-overflow detection.
module cpa_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
`ifdef DSA_OVERFLOW_EN
  output logic             msb_ci,
`endif
  output logic             co
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co = c[DIGIT];

`ifdef DSA_OVERFLOW_EN
  assign msb_ci = c[DIGIT-1];
`endif

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor reusing one DIGIT-bit ripple adder,
// LSB digit first. Define DSA_OVERFLOW_EN to add the signed-overflow flag OVF.
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  digit_serial_addsub_if.slave bus
);

  localparam int             NDIG    = dsa_ndig(WIDTH, DIGIT);
  localparam int             CW      = dsa_cnt_w(NDIG);
  localparam logic [CW-1:0]  LAST    = CW'(NDIG - 1);
  localparam logic [0:0]     ST_IDLE = IDLE;
  localparam logic [0:0]     ST_RUN  = RUN;

  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             done_q;
  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic [WIDTH-1:0] s_nxt;
`ifdef DSA_OVERFLOW_EN
  logic             dig_msb_ci;
  logic             ovf_q;
`endif

  cpa_digit #(
    .DIGIT (DIGIT)
  ) u_cpa (
    .a      (a_sr[DIGIT-1:0]),
    .b      (b_sr[DIGIT-1:0]),
    .ci     (carry),
    .s      (dig_s),
`ifdef DSA_OVERFLOW_EN
    .msb_ci (dig_msb_ci),
`endif
    .co     (dig_co)
  );

  // The result fills from the MSB end so the first digit lands at bit 0 after NDIG shifts.
  always_comb begin
    s_nxt = (s_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      s_q    <= '0;
      co_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef DSA_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            a_sr  <= bus.A;
            b_sr  <= bus.B ^ {WIDTH{bus.SUB}};
            carry <= bus.SUB ? 1'b1 : bus.Ci;
            cnt   <= '0;
            s_q   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_q   <= s_nxt;
          carry <= dig_co;
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= ST_IDLE;
            co_q   <= dig_co;
            done_q <= 1'b1;
`ifdef DSA_OVERFLOW_EN
            ovf_q  <= dig_co ^ dig_msb_ci;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.BUSY = (state == ST_RUN);
  assign bus.DONE = done_q;
  assign bus.S    = s_q;
  assign bus.Co   = co_q;
`ifdef DSA_OVERFLOW_EN
  assign bus.OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Randomised self-checking bench for digit_serial_addsub, exercising DIGIT=4, 1
// and 16 side by side against an integer-arithmetic reference.
module tb_digit_serial_addsub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   st  = 3'b000;
  logic         sub = 1'b0;
  logic         ci  = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_serial_addsub_if #(.WIDTH(W)) bus4 ();
  digit_serial_addsub_if #(.WIDTH(W)) bus1 ();
  digit_serial_addsub_if #(.WIDTH(W)) bus16 ();

  digit_serial_addsub #(.WIDTH(W), .DIGIT(4))  dut4  (.CLK(clk), .RST(rst), .bus(bus4));
  digit_serial_addsub #(.WIDTH(W), .DIGIT(1))  dut1  (.CLK(clk), .RST(rst), .bus(bus1));
  digit_serial_addsub #(.WIDTH(W), .DIGIT(16)) dut16 (.CLK(clk), .RST(rst), .bus(bus16));

  assign bus4.START  = st[0];
  assign bus1.START  = st[1];
  assign bus16.START = st[2];
  assign bus4.SUB  = sub;  assign bus1.SUB  = sub;  assign bus16.SUB  = sub;
  assign bus4.Ci   = ci;   assign bus1.Ci   = ci;   assign bus16.Ci   = ci;
  assign bus4.A    = a;    assign bus1.A    = a;    assign bus16.A    = a;
  assign bus4.B    = b;    assign bus1.B    = b;    assign bus16.B    = b;

  logic [2:0]   busy, done, co;
  logic [W-1:0] s_o [3];
  assign busy = {bus16.BUSY, bus1.BUSY, bus4.BUSY};
  assign done = {bus16.DONE, bus1.DONE, bus4.DONE};
  assign co   = {bus16.Co,   bus1.Co,   bus4.Co};
  assign s_o[0] = bus4.S;
  assign s_o[1] = bus1.S;
  assign s_o[2] = bus16.S;
`ifdef DSA_OVERFLOW_EN
  logic [2:0] ovf;
  assign ovf = {bus16.OVF, bus1.OVF, bus4.OVF};
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ndig_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  // Unsigned result with carry/no-borrow in bit W.
  function automatic logic [W:0] ref_sum(input logic sb, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic c);
    if (sb) return {1'b0, x} + (17'h1 << W) - {1'b0, y};
    return {1'b0, x} + {1'b0, y} + {16'h0, c};
  endfunction

  function automatic logic ref_ovf(input logic sb, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic c);
    int sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    r  = sb ? (sx - sy) : (sx + sy + int'(c));
    return (r > 32767) || (r < -32768);
  endfunction

  // One operation on all three instances; optionally pokes dut4 with a START while busy.
  task automatic run_op(input logic sb, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic cc, input bit poke);
    logic [W:0] e;
    int lat [3];
    int nd  [3];
    e = ref_sum(sb, aa, bb, cc);
    @(negedge clk);
    sub = sb; a = aa; b = bb; ci = cc; st = 3'b111;
    @(posedge clk); #1;
    st = 3'b000;
    for (int i = 0; i < 3; i++) begin lat[i] = -1; nd[i] = 0; end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          nd[i]++;
          if (lat[i] < 0) lat[i] = k;
          chk($sformatf("S_d%0d", ndig_of(i)), 32'(s_o[i]), 32'(e[W-1:0]));
          chk($sformatf("Co_d%0d", ndig_of(i)), 32'(co[i]), 32'(e[W]));
`ifdef DSA_OVERFLOW_EN
          chk($sformatf("OVF_d%0d", ndig_of(i)), 32'(ovf[i]), 32'(ref_ovf(sb, aa, bb, cc)));
`endif
        end
      end
      if (k <= 4) chk("busy_d4", 32'(busy[0]), 32'(k < 4));
      if (poke && k == 1) begin a = 16'h0F0F; b = ~bb; sub = ~sb; st[0] = 1'b1; end
      if (poke && k == 2) st[0] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency_d%0d", ndig_of(i)), 32'(lat[i]), 32'(ndig_of(i)));
      chk($sformatf("ndone_d%0d", ndig_of(i)), 32'(nd[i]), 32'd1);
      chk($sformatf("Shold_d%0d", ndig_of(i)), 32'(s_o[i]), 32'(e[W-1:0]));
      chk($sformatf("busy_end_d%0d", ndig_of(i)), 32'(busy[i]), 32'd0);
    end
  endtask

  initial begin
    logic [W:0] e1, e2;
    int t1, t2, nd_any;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_done", 32'(done[i]), 32'd0);
      chk("rst_S", 32'(s_o[i]), 32'd0);
      chk("rst_Co", 32'(co[i]), 32'd0);
    end
    rst = 1'b0;

    run_op(1'b0, 16'hFFFE, 16'h0001, 1'b0, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0);
    run_op(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0);
    run_op(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
    run_op(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b1);
    for (int n = 0; n < 30; n++)
      run_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    // Back-to-back on dut4: START held through the DONE cycle starts a second op.
    e1 = ref_sum(1'b0, 16'h1111, 16'h2222, 1'b0);
    e2 = ref_sum(1'b1, 16'h0100, 16'h0023, 1'b1);
    @(negedge clk);
    sub = 1'b0; a = 16'h1111; b = 16'h2222; ci = 1'b0; st = 3'b001;
    @(posedge clk); #1;
    sub = 1'b1; a = 16'h0100; b = 16'h0023; ci = 1'b1;
    t1 = -1; t2 = -1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (done[0]) begin
        if (t1 < 0) begin
          t1 = k;
          chk("b2b_S1", 32'(s_o[0]), 32'(e1[W-1:0]));
          chk("b2b_Co1", 32'(co[0]), 32'(e1[W]));
        end else begin
          t2 = k;
          chk("b2b_S2", 32'(s_o[0]), 32'(e2[W-1:0]));
          chk("b2b_Co2", 32'(co[0]), 32'(e2[W]));
        end
      end
      if (k == 5) st[0] = 1'b0;
    end
    chk("b2b_t1", 32'(t1), 32'd4);
    chk("b2b_t2", 32'(t2), 32'd9);

    // Reset in the middle of a run: everything clears and no DONE follows.
    @(negedge clk);
    sub = 1'b0; a = 16'hABCD; b = 16'h1234; ci = 1'b0; st = 3'b101;
    @(posedge clk); #1;
    st = 3'b000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rrun_busy", 32'(busy[0]), 32'd0);
    chk("rrun_done", 32'(done[0]), 32'd0);
    chk("rrun_S", 32'(s_o[0]), 32'd0);
    chk("rrun_Co", 32'(co[0]), 32'd0);
    chk("rrun_busy_d1", 32'(busy[2]), 32'd0);
    nd_any = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done != 3'b000) nd_any++;
    end
    chk("rrun_nodone", 32'(nd_any), 32'd0);

    // Reset has priority over a simultaneous START.
    @(negedge clk);
    rst = 1'b1; st = 3'b111;
    @(posedge clk); #1;
    rst = 1'b0; st = 3'b000;
    chk("rst_prio_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
